// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states, register address type,
// and the priority-mux action encoding.
package pipe_ctrl_pkg;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t R0 = '0;

   typedef enum logic {
      RUN,
      WAIT
   } mem_state_t;

   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_MEM_FREEZE,
      ACT_FLUSH,
      ACT_STALL
   } ctrl_action_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side is master, the controller is slave.
// The controller has no backpressure of its own; every signal is sampled or driven each cycle.
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
);
   reg_addr_t        src1;
   reg_addr_t        src2;
   logic             two_src;
   reg_addr_t        exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   reg_addr_t        mem_dest;
   logic             mem_wb_en;
   logic             br_taken;
   logic             mem_req;
   logic             freeze_if;
   logic             flush_ifid;
   logic             bubble_idex;
   logic             freeze_all;
   logic             mem_done;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
             mem_dest, mem_wb_en, br_taken, mem_req,
      input  freeze_if, flush_ifid, bubble_idex, freeze_all, mem_done, stall_cycles
   );

   modport slave (
      input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
             mem_dest, mem_wb_en, br_taken, mem_req,
      output freeze_if, flush_ifid, bubble_idex, freeze_all, mem_done, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW detector, zero latency, no backpressure. Macro FWD_EN: when defined a
// forwarding unit exists and only load-use hazards stall; otherwise any EXE/MEM producer stalls.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  reg_addr_t src1,
   input  reg_addr_t src2,
   input  logic      two_src,
   input  reg_addr_t exe_dest,
   input  logic      exe_wb_en,
   input  logic      exe_mem_r_en,
   input  reg_addr_t mem_dest,
   input  logic      mem_wb_en,
   output logic      hazard
);
   function automatic logic raw_hit(input reg_addr_t d, input logic en,
                                    input reg_addr_t s1, input reg_addr_t s2,
                                    input logic two);
      return en && (d != R0) && ((d == s1) || (two && (d == s2)));
   endfunction

   logic load_use;
   assign load_use = raw_hit(exe_dest, exe_mem_r_en, src1, src2, two_src);

`ifdef FWD_EN
   assign hazard = load_use;
`else
   // A load-use with WB enabled is already an EXE hit; OR-ing it keeps one load-use net in both builds.
   assign hazard = raw_hit(exe_dest, exe_wb_en, src1, src2, two_src)
                || raw_hit(mem_dest, mem_wb_en, src1, src2, two_src)
                || (load_use && exe_wb_en);
`endif
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: SRAM freeze FSM, branch flush, RAW stall, saturating stall counter.
// Outputs are combinational from inputs and state (0 latency); no backpressure. Macro FWD_EN selects hazard rule.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 4,
   parameter int CNT_W   = 16
)(
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave bus
);
   localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

   mem_state_t       state;
   logic [3:0]       cnt;
   logic [CNT_W-1:0] stall_q;
   logic             hazard;
   logic             mem_freeze;
   logic             mem_fin;
   ctrl_action_t     act;

   hazard_detect u_hazard (
      .src1         (bus.src1),
      .src2         (bus.src2),
      .two_src      (bus.two_src),
      .exe_dest     (bus.exe_dest),
      .exe_wb_en    (bus.exe_wb_en),
      .exe_mem_r_en (bus.exe_mem_r_en),
      .mem_dest     (bus.mem_dest),
      .mem_wb_en    (bus.mem_wb_en),
      .hazard       (hazard)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (bus.mem_req && (MEM_LAT > 1)) begin
                  state <= WAIT;
                  cnt   <= WAIT_INIT;
               end
            end
            WAIT: begin
               if (cnt == '0) state <= RUN;
               else           cnt   <= cnt - 4'd1;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_comb begin
      mem_freeze = 1'b0;
      mem_fin    = 1'b0;
      case (state)
         RUN: begin
            if (bus.mem_req) begin
               if (MEM_LAT > 1) mem_freeze = 1'b1;
               else             mem_fin    = 1'b1;
            end
         end
         WAIT: begin
            if (cnt != '0) mem_freeze = 1'b1;
            else           mem_fin    = 1'b1;
         end
         default: ;
      endcase
   end

   // Memory freeze holds branch/hazard pending; a taken branch makes the hazarding instruction wrong-path.
   always_comb begin
      act = ACT_NONE;
      if (mem_freeze)        act = ACT_MEM_FREEZE;
      else if (bus.br_taken) act = ACT_FLUSH;
      else if (hazard)       act = ACT_STALL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if ((act == ACT_STALL) && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign bus.freeze_all   = !rst && (act == ACT_MEM_FREEZE);
   assign bus.freeze_if    = !rst && ((act == ACT_MEM_FREEZE) || (act == ACT_STALL));
   assign bus.flush_ifid   = !rst && (act == ACT_FLUSH);
   assign bus.bubble_idex  = !rst && ((act == ACT_FLUSH) || (act == ACT_STALL));
   assign bus.mem_done     = !rst && mem_fin;
   assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int MEM_LAT   = 4;
   localparam int CNT_W     = 16;
   localparam int STALL_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   // Model state: m_age = cycles into the current SRAM access (0 = no access), m_stall = stall count.
   int m_age   = 0;
   int m_stall = 0;

   function automatic bit dep(int d, bit en, int s1, int s2, bit two);
      return en && (d != 0) && ((d == s1) || (two && (d == s2)));
   endfunction

   function automatic bit model_hazard();
      int s1 = int'(bus.src1);
      int s2 = int'(bus.src2);
`ifdef FWD_EN
      return dep(int'(bus.exe_dest), bus.exe_mem_r_en, s1, s2, bus.two_src);
`else
      return dep(int'(bus.exe_dest), bus.exe_wb_en, s1, s2, bus.two_src)
          || dep(int'(bus.mem_dest), bus.mem_wb_en, s1, s2, bus.two_src);
`endif
   endfunction

   function automatic int eff_age();
      if (m_age > 0) return m_age;
      return bus.mem_req ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      int  e;
      bit  frz, done, br, hz;
      if (rst) begin
         chk("rst_freeze_all", bus.freeze_all, 0);
         chk("rst_freeze_if", bus.freeze_if, 0);
         chk("rst_flush_ifid", bus.flush_ifid, 0);
         chk("rst_bubble_idex", bus.bubble_idex, 0);
         chk("rst_mem_done", bus.mem_done, 0);
         chk("rst_stall_cycles", bus.stall_cycles, 0);
      end else begin
         e    = eff_age();
         frz  = (e > 0) && (e < MEM_LAT);
         done = (e == MEM_LAT);
         br   = bus.br_taken;
         hz   = model_hazard();
         chk("freeze_all", bus.freeze_all, frz);
         chk("freeze_if", bus.freeze_if, frz || (!br && hz));
         chk("flush_ifid", bus.flush_ifid, !frz && br);
         chk("bubble_idex", bus.bubble_idex, !frz && (br || hz));
         chk("mem_done", bus.mem_done, done);
         chk("stall_cycles", bus.stall_cycles, m_stall);
      end
   endtask

   task automatic advance();
      int e;
      bit frz, done;
      if (rst) begin
         m_age   = 0;
         m_stall = 0;
      end else begin
         e    = eff_age();
         frz  = (e > 0) && (e < MEM_LAT);
         done = (e == MEM_LAT);
         if (!frz && !bus.br_taken && model_hazard() && (m_stall < STALL_MAX))
            m_stall = m_stall + 1;
         m_age = done ? 0 : ((e > 0) ? e + 1 : 0);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic drive(input int s1, input int s2, input bit two,
                        input int ed, input bit ewb, input bit emr,
                        input int md, input bit mwb, input bit br, input bit mreq);
      bus.src1         = reg_addr_t'(s1);
      bus.src2         = reg_addr_t'(s2);
      bus.two_src      = two;
      bus.exe_dest     = reg_addr_t'(ed);
      bus.exe_wb_en    = ewb;
      bus.exe_mem_r_en = emr;
      bus.mem_dest     = reg_addr_t'(md);
      bus.mem_wb_en    = mwb;
      bus.br_taken     = br;
      bus.mem_req      = mreq;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();

      // Load-use on r3, then the load moves to MEM.
      drive(3, 0, 0, 3, 1, 1, 0, 0, 0, 0);
      step();
      drive(3, 0, 0, 0, 0, 0, 3, 1, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // MEM-stage producer on src2, with and without two_src; r0 never hazards.
      drive(1, 5, 1, 0, 0, 0, 5, 1, 0, 0);
      step();
      drive(1, 5, 0, 0, 0, 0, 5, 1, 0, 0);
      step();
      drive(0, 0, 1, 0, 1, 1, 0, 1, 0, 0);
      step();

      // Single SRAM access, then two back-to-back accesses.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (2 * MEM_LAT) step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) step();

      // Branch together with a load-use hazard.
      drive(3, 0, 0, 3, 1, 1, 0, 0, 1, 0);
      step();

      // Branch held across an SRAM wait.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      drive(3, 0, 0, 3, 1, 1, 0, 0, 1, 0);
      repeat (MEM_LAT) step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Reset asserted while waiting with cnt=1.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      rst = 1'b1;
      #1;
      check_outputs();
      step();
      rst = 1'b0;
      repeat (5) step();

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
         step();
      end

      // Drive a permanent load-use hazard long enough to saturate the counter.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      repeat (STALL_MAX + 20) step();
      chk("stall_saturated", bus.stall_cycles, STALL_MAX);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It detects RAW hazards between the ID-stage sources and the EXE/MEM destinations, and it squashes wrong-path instructions on a taken branch. It also freezes the whole pipeline while a multi-cycle SRAM access completes. Its outputs drive the PC/IF-ID freeze, the IF-ID flush and the bubble (control clear) of the ID-to-EXE stage register.

Parameters:
MEM_LAT, 4, SRAM access cycles including the issue cycle (legal range 1..16).
REG_ADDR_W, 5, register-file address width.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  input  1  pipeline clock.
rst  input  1  asynchronous, active-high reset.
src1  input  REG_ADDR_W  ID-stage source register 1.
src2  input  REG_ADDR_W  ID-stage source register 2.
two_src  input  1  ID instruction reads src2 (not immediate-only).
exe_dest  input  REG_ADDR_W  destination held in ID/EXE register.
exe_wb_en  input  1  WB enable of EXE-stage instruction.
exe_mem_r_en  input  1  EXE-stage instruction is a load.
mem_dest  input  REG_ADDR_W  destination of MEM-stage instruction.
mem_wb_en  input  1  WB enable of MEM-stage instruction.
br_taken  input  1  EXE stage resolved a taken branch.
mem_req  input  1  MEM-stage instruction has MEM_R_En or MEM_W_En set.
freeze_if  output  1  hold PC and IF/ID register.
flush_ifid  output  1  clear IF/ID instruction to NOP.
bubble_idex  output  1  ID/EXE register loads zero control (WB_En, MEM_R_En, MEM_W_En, BR_Type, EXE_Cmd).
freeze_all  output  1  hold every pipeline register, PC included.
mem_done  output  1  SRAM access completes this cycle.
stall_cycles  output  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset: FSM to RUN, wait counter to 0, stall_cycles to 0. While rst is high, every output is 0. Reset mid-access aborts the access with no mem_done.
- Register 0 never hazards: any dest compare with dest==0 is false.
- raw_hit(d,en) is true when en && d!=0 && (d==src1 || (two_src && d==src2)).
- hazard (with FWD_EN): raw_hit(exe_dest, exe_mem_r_en) (load-use only).
- Memory FSM states: RUN, WAIT.
  - RUN, mem_req=1, MEM_LAT>1: freeze_all=1, cnt<=MEM_LAT-2, next WAIT.
  - RUN, mem_req=1, MEM_LAT==1: mem_done=1, freeze_all=0, stay RUN.
  - WAIT, cnt!=0: freeze_all=1, cnt<=cnt-1.
  - WAIT, cnt==0: freeze_all=0, mem_done=1, next RUN.
  - Result: exactly MEM_LAT-1 frozen cycles per access. Back-to-back memory ops restart from RUN in the cycle after mem_done.
- Priority, combinational, evaluated each cycle:
  1. freeze_all=1: freeze_if=1, flush_ifid=0, bubble_idex=0. Branch and hazard are held, not acted on.
  2. else br_taken: flush_ifid=1, bubble_idex=1, freeze_if=0. A branch overrides a hazard because the hazard instruction is wrong-path.
  3. else hazard: freeze_if=1, bubble_idex=1, flush_ifid=0.
  4. else: all 0.
- stall_cycles increments on every cycle in case 3 and saturates at all-ones.
- Latency: outputs are combinational from inputs and state. Only state, cnt and stall_cycles are registered.

Optional Feature:
FWD_EN:
- Defined: a forwarding unit exists. hazard is the load-use term only, so a load-use produces a 1-cycle stall.
- Undefined: hazard = raw_hit(exe_dest, exe_wb_en) || raw_hit(mem_dest, mem_wb_en). A dependent instruction therefore stalls until its producer leaves MEM (up to 2 cycles).

Decomposition:
- Package pipe_ctrl_pkg holds: the FSM state enum (RUN, WAIT), REG_ADDR_W, the R0 constant, and the ctrl_action encoding used for the priority mux.
- Sub-module hazard_detect is purely combinational: raw compares plus the FWD_EN selection. The FSM, priority mux and counter stay at top level.

Test Plan:
- Load to r3 in EXE (exe_mem_r_en=1, exe_dest=3), ID src1=3 -> one cycle freeze_if=1, bubble_idex=1, stall_cycles 0->1, then all 0 once the load moves to MEM (with FWD_EN).
- Without FWD_EN: mem_dest=5, mem_wb_en=1, src2=5, two_src=1 -> freeze_if=1, bubble_idex=1. Same case with two_src=0 -> no stall. dest=0 with src1=0 -> no stall.
- MEM_LAT=4, mem_req pulse -> freeze_all high for 3 cycles, mem_done on the 4th cycle. Repeated with mem_req held for 2 consecutive ops -> 3+3 frozen cycles and two mem_done pulses.
- br_taken=1 together with a load-use hazard -> flush_ifid=1, bubble_idex=1, freeze_if=0, and stall_cycles unchanged.
- br_taken=1 during WAIT -> flush_ifid stays 0 until the cycle mem_done=1, then flush_ifid=1 and bubble_idex=1 in that cycle.
- rst asserted in WAIT (cnt=1) -> all outputs 0 immediately. After release, the FSM is in RUN and no mem_done is issued. Separately, force 65535 hazard cycles and then more -> stall_cycles holds at 16'hFFFF.
